// File: rtl/mem_adapter_pkg.sv
// Shared types and helpers for the processor-to-memory access adapter.
// Sizes encode log2 of the byte count; states track the two-access sequence.
package mem_adapter_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;
  typedef enum logic [1:0] {IDLE, FIRST, SECOND, RESP} state_t;

  localparam int unsigned LANES = 8;

  function automatic logic [3:0] byte_count(input size_t sz);
    case (sz)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [LANES-1:0] lane_mask(input size_t sz);
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store mask/data for either half of a
// possibly split access, and load data merge with sign/zero extension.
module mem_lane_align
  import mem_adapter_pkg::*;
(
  input  logic [2:0]  i_off,
  input  size_t       i_size,
  input  logic        i_part,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rd0,
  input  logic [63:0] i_rd1,
  input  logic        i_signed,
  output logic        o_split,
  output logic [7:0]  o_mask,
  output logic [63:0] o_wdata,
  output logic [63:0] o_rdata
);

  logic [15:0]  w_mask_wide;
  logic [127:0] w_wdata_wide;
  logic [127:0] w_rd_wide;
  logic [7:0]   w_lanes;
  logic [63:0]  w_keep;
  logic [63:0]  w_raw;
  logic [5:0]   w_sbit;
  logic         w_sign;

  always_comb begin
    w_lanes      = lane_mask(i_size);
    // Shifting into a double-width window yields both access halves at once.
    w_mask_wide  = {8'h00, w_lanes} << i_off;
    w_wdata_wide = {64'h0, i_wdata} << {i_off, 3'b000};
    o_split      = ({1'b0, i_off} + byte_count(i_size)) > 4'd8;
    o_mask       = i_part ? w_mask_wide[15:8] : w_mask_wide[7:0];
    o_wdata      = i_part ? w_wdata_wide[127:64] : w_wdata_wide[63:0];

    w_keep = '0;
    for (int i = 0; i < 8; i++) begin
      w_keep[8*i +: 8] = {8{w_lanes[i]}};
    end
    w_rd_wide = {i_rd1, i_rd0} >> {i_off, 3'b000};
    w_raw     = w_rd_wide[63:0] & w_keep;
    w_sbit    = {3'(byte_count(i_size) - 4'd1), 3'b111};
    w_sign    = i_signed & w_raw[w_sbit];
    o_rdata   = w_raw | (w_sign ? ~w_keep : 64'h0);
  end

endmodule

// File: rtl/mem_access_adapter.sv
// Converts byte-addressed loads/stores of 1/2/4/8 bytes into one or two
// aligned 64-bit memory accesses and returns merged, extended load data.
//   state  | meaning
//   IDLE   | ready for a request
//   FIRST  | access to the aligned word holding the first byte
//   SECOND | access to the following word when the request straddles it
//   RESP   | one-cycle response pulse
module mem_access_adapter
  import mem_adapter_pkg::*;
#(
  parameter int DMEM_ADDRESS_WIDTH = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [DMEM_ADDRESS_WIDTH-1:0] req_addr,
  input  logic                          req_write,
  input  logic [1:0]                    req_size,
  input  logic                          req_signed,
  input  logic [63:0]                   req_wdata,
  output logic                          resp_valid,
  output logic [63:0]                   resp_rdata,
  output logic [DMEM_ADDRESS_WIDTH-1:0] mem_address,
  output logic [63:0]                   mem_data_in,
  output logic [7:0]                    mem_bytemask,
  output logic                          mem_write,
  output logic                          mem_start_access,
  input  logic                          mem_access_done,
  input  logic [63:0]                   mem_data_out
);

  localparam int AW = DMEM_ADDRESS_WIDTH;

  state_t          r_state;
  state_t          w_state_nx;
  logic [2:0]      r_off;
  size_t           r_size;
  logic            r_write;
  logic            r_signed;
  logic            r_split;
  logic [63:0]     r_wdata;
  logic [63:0]     r_rd0;
  logic [63:0]     r_rd1;
  logic [AW-1:0]   r_mem_address;
  logic [63:0]     r_mem_data_in;
  logic [7:0]      r_mem_bytemask;
  logic            r_mem_write;
  logic            r_mem_start;

  logic            w_in_idle;
  logic            w_accept;
  logic [2:0]      w_off;
  size_t           w_size;
  logic [63:0]     w_wdata_src;
  logic            w_split;
  logic [7:0]      w_lane_mask;
  logic [63:0]     w_lane_wdata;
  logic [63:0]     w_rdata;

  assign w_in_idle   = (r_state == IDLE);
  assign req_ready   = w_in_idle && !reset;
  assign w_accept    = req_valid && req_ready;

  // In IDLE the aligner sees the live request (first access); afterwards the
  // latched copy, so the same instance also produces the second access.
  assign w_off       = w_in_idle ? req_addr[2:0] : r_off;
  assign w_size      = w_in_idle ? size_t'(req_size) : r_size;
  assign w_wdata_src = w_in_idle ? req_wdata : r_wdata;

  mem_lane_align u_align (
    .i_off    (w_off),
    .i_size   (w_size),
    .i_part   (!w_in_idle),
    .i_wdata  (w_wdata_src),
    .i_rd0    (r_rd0),
    .i_rd1    (r_rd1),
    .i_signed (r_signed),
    .o_split  (w_split),
    .o_mask   (w_lane_mask),
    .o_wdata  (w_lane_wdata),
    .o_rdata  (w_rdata)
  );

  assign mem_address      = r_mem_address;
  assign mem_data_in      = r_mem_data_in;
  assign mem_bytemask     = r_mem_bytemask;
  assign mem_write        = r_mem_write;
  assign mem_start_access = r_mem_start;
  assign resp_valid       = (r_state == RESP);
  assign resp_rdata       = (resp_valid && !r_write) ? w_rdata : 64'h0;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nx = FIRST;
      FIRST:   if (mem_access_done) w_state_nx = r_split ? SECOND : RESP;
      SECOND:  if (mem_access_done) w_state_nx = RESP;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_off          <= '0;
      r_size         <= SZ_B;
      r_write        <= 1'b0;
      r_signed       <= 1'b0;
      r_split        <= 1'b0;
      r_wdata        <= '0;
      r_rd0          <= '0;
      r_rd1          <= '0;
      r_mem_address  <= '0;
      r_mem_data_in  <= '0;
      r_mem_bytemask <= '0;
      r_mem_write    <= 1'b0;
      r_mem_start    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_off          <= req_addr[2:0];
            r_size         <= size_t'(req_size);
            r_write        <= req_write;
            r_signed       <= req_signed;
            r_split        <= w_split;
            r_wdata        <= req_wdata;
            r_mem_address  <= {req_addr[AW-1:3], 3'b000};
            r_mem_data_in  <= w_lane_wdata;
            r_mem_bytemask <= w_lane_mask;
            r_mem_write    <= req_write;
            r_mem_start    <= 1'b1;
          end
        end
        FIRST: begin
          if (mem_access_done) begin
            r_rd0 <= mem_data_out;
            r_rd1 <= '0;
            // Split: start_access stays high so the second access follows back-to-back.
            if (r_split) begin
              r_mem_address  <= r_mem_address + AW'(8);
              r_mem_data_in  <= w_lane_wdata;
              r_mem_bytemask <= w_lane_mask;
            end else begin
              r_mem_start <= 1'b0;
            end
          end
        end
        SECOND: begin
          if (mem_access_done) begin
            r_rd1       <= mem_data_out;
            r_mem_start <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  a_done_only_when_busy: assert property (@(posedge clk) disable iff (reset)
    !(mem_access_done && (r_state == IDLE || r_state == RESP)));

endmodule

// File: tb/tb_mem_access_adapter.sv
// Bench for mem_access_adapter: word-wide memory model with variable latency,
// byte-level reference model, per-cycle protocol/data compare, literal pins.
module tb_mem_access_adapter;
  import mem_adapter_pkg::*;

  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [63:0]   req_wdata;
  logic          resp_valid;
  logic [63:0]   resp_rdata;
  logic [AW-1:0] mem_address;
  logic [63:0]   mem_data_in;
  logic [7:0]    mem_bytemask;
  logic          mem_write;
  logic          mem_start_access;
  logic          mem_access_done = 1'b0;
  logic [63:0]   mem_data_out = 64'h0;

  mem_access_adapter #(.DMEM_ADDRESS_WIDTH(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_signed       (req_signed),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in),
    .mem_bytemask     (mem_bytemask),
    .mem_write        (mem_write),
    .mem_start_access (mem_start_access),
    .mem_access_done  (mem_access_done),
    .mem_data_out     (mem_data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    mask;
    logic [63:0]   data;
    logic          wr;
  } acc_t;

  acc_t        exp_acc[$];
  acc_t        obs_acc[$];
  logic [63:0] exp_resp[$];
  logic [63:0] last_rdata = 64'h0;
  logic [63:0] dmem[int];
  logic [7:0]  ref_mem[int];
  int          checks = 0;
  int          errors = 0;
  int          n_accept = 0;
  int          n_resp = 0;
  int          resp_goal = 0;
  int          mem_lat = 0;

  function automatic logic [63:0] lane_bits(input logic [7:0] m);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory: answers each access after mem_lat idle cycles; writes take effect on the done edge.
  initial begin
    int lat;
    int w;
    logic [63:0] cur;
    logic [63:0] lb;
    lat = 0;
    forever begin
      @(posedge clk); #1;
      mem_data_out = {$urandom, $urandom};
      if (reset) begin
        mem_access_done = 1'b0;
        lat = 0;
      end else if (mem_access_done) begin
        mem_access_done = 1'b0;
        lat = 0;
      end else if (mem_start_access) begin
        if (lat >= mem_lat) begin
          w   = int'(mem_address >> 3);
          cur = dmem.exists(w) ? dmem[w] : 64'h0;
          mem_data_out = cur;
          if (mem_write) begin
            lb = lane_bits(mem_bytemask);
            dmem[w] = (cur & ~lb) | (mem_data_in & lb);
          end
          mem_access_done = 1'b1;
        end else begin
          lat++;
        end
      end
    end
  end

  // Per-cycle compare against the reference expectations.
  initial begin
    logic [AW-1:0] p_addr;
    logic [7:0]    p_mask;
    logic [63:0]   p_data;
    logic          p_wr;
    logic          p_start;
    logic          p_done;
    acc_t          e;
    acc_t          o;
    p_start = 1'b0;
    p_done  = 1'b0;
    p_addr  = '0;
    p_mask  = '0;
    p_data  = '0;
    p_wr    = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        p_start = 1'b0;
        p_done  = 1'b0;
      end else begin
        check("addr_aligned", 64'(mem_address[2:0]), 64'h0);
        if (p_start && !p_done) begin
          check("hold_start", 64'(mem_start_access), 64'h1);
          check("hold_addr", 64'(mem_address), 64'(p_addr));
          check("hold_mask", 64'(mem_bytemask), 64'(p_mask));
          check("hold_data", mem_data_in, p_data);
          check("hold_write", 64'(mem_write), 64'(p_wr));
        end
        if (mem_start_access && mem_access_done) begin
          o.addr = mem_address;
          o.mask = mem_bytemask;
          o.data = mem_data_in;
          o.wr   = mem_write;
          obs_acc.push_back(o);
          if (exp_acc.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_access actual=%h required=none", mem_address);
          end else begin
            e = exp_acc.pop_front();
            check("acc_addr", 64'(mem_address), 64'(e.addr));
            check("acc_mask", 64'(mem_bytemask), 64'(e.mask));
            check("acc_write", 64'(mem_write), 64'(e.wr));
            if (e.wr) check("acc_data", mem_data_in & lane_bits(mem_bytemask), e.data);
          end
        end
        if (resp_valid) begin
          n_resp++;
          last_rdata = resp_rdata;
          if (exp_resp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp actual=%h required=none", resp_rdata);
          end else begin
            check("resp_rdata", resp_rdata, exp_resp.pop_front());
          end
        end
        p_start = mem_start_access;
        p_done  = mem_access_done;
        p_addr  = mem_address;
        p_mask  = mem_bytemask;
        p_data  = mem_data_in;
        p_wr    = mem_write;
      end
    end
  end

  // Builds expectations from byte-level rules, then presents and hands off the request.
  task automatic start_req(input logic [AW-1:0] a, input logic w, input logic [1:0] sz,
                           input logic sg, input logic [63:0] wd);
    acc_t          a0;
    acc_t          a1;
    logic [63:0]   rexp;
    logic [AW-1:0] ba;
    logic          two;
    int            n;
    int            d;
    int            t;
    n       = 1 << sz;
    a0.addr = {a[AW-1:3], 3'b000};
    a1.addr = a0.addr + AW'(8);
    a0.mask = '0;
    a1.mask = '0;
    a0.data = '0;
    a1.data = '0;
    a0.wr   = w;
    a1.wr   = w;
    two     = 1'b0;
    rexp    = '0;
    for (int i = 0; i < n; i++) begin
      d  = int'(a[2:0]) + i;
      ba = a + AW'(i);
      if (d < 8) begin
        a0.mask[d] = 1'b1;
        a0.data[8*d +: 8] = wd[8*i +: 8];
      end else begin
        a1.mask[d-8] = 1'b1;
        a1.data[8*(d-8) +: 8] = wd[8*i +: 8];
        two = 1'b1;
      end
      if (w) ref_mem[int'(ba)] = wd[8*i +: 8];
      else   rexp[8*i +: 8] = ref_mem.exists(int'(ba)) ? ref_mem[int'(ba)] : 8'h00;
    end
    if (!w && sg && rexp[8*n-1])
      for (int i = n; i < 8; i++) rexp[8*i +: 8] = 8'hFF;
    exp_acc.push_back(a0);
    if (two) exp_acc.push_back(a1);
    exp_resp.push_back(rexp);
    obs_acc.delete();

    t = 0;
    while (!req_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("ready_wait", 64'(req_ready), 64'h1);
    req_addr   = a;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_wdata  = wd;
    req_valid  = 1'b1;
    resp_goal  = n_resp + 1;
    @(posedge clk); #1;
    n_accept++;
    req_valid  = 1'b0;
    req_addr   = AW'($urandom);
    req_wdata  = {$urandom, $urandom};
    req_size   = 2'($urandom);
    req_signed = ~sg;
    req_write  = ~w;
  endtask

  task automatic wait_resp();
    int t;
    t = 0;
    while (n_resp < resp_goal && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("resp_arrived", 64'(n_resp >= resp_goal), 64'h1);
  endtask

  task automatic do_req(input logic [AW-1:0] a, input logic w, input logic [1:0] sz,
                        input logic sg, input logic [63:0] wd);
    start_req(a, w, sz, sg, wd);
    wait_resp();
  endtask

  function automatic acc_t obs(input int i);
    acc_t r;
    r.addr = '1;
    r.mask = '0;
    r.data = '0;
    r.wr   = 1'b0;
    if (i < obs_acc.size()) r = obs_acc[i];
    return r;
  endfunction

  initial begin
    acc_t o;
    int   t;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_write  = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_wdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("ready_in_reset", 64'(req_ready), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ready", 64'(req_ready), 64'h1);
    check("rst_start", 64'(mem_start_access), 64'h0);
    check("rst_resp_valid", 64'(resp_valid), 64'h0);
    check("rst_rdata", resp_rdata, 64'h0);
    check("rst_addr", 64'(mem_address), 64'h0);
    check("rst_mask", 64'(mem_bytemask), 64'h0);
    check("rst_data_in", mem_data_in, 64'h0);
    check("rst_write", 64'(mem_write), 64'h0);

    mem_lat = 0;
    do_req(20'h00013, 1'b1, 2'd0, 1'b0, 64'h00000000000000AB);
    o = obs(0);
    check("stb_count", 64'(obs_acc.size()), 64'd1);
    check("stb_addr", 64'(o.addr), 64'h10);
    check("stb_mask", 64'(o.mask), 64'h08);
    check("stb_byte", 64'(o.data[31:24]), 64'hAB);
    check("stb_rdata_zero", last_rdata, 64'h0);
    do_req(20'h00013, 1'b0, 2'd0, 1'b0, 64'h0);
    check("ldb_0x13", last_rdata, 64'h00000000000000AB);

    mem_lat = 1;
    do_req(20'h0000C, 1'b1, 2'd3, 1'b0, 64'h1122334455667788);
    check("std_count", 64'(obs_acc.size()), 64'd2);
    o = obs(0);
    check("std_a1_addr", 64'(o.addr), 64'h08);
    check("std_a1_mask", 64'(o.mask), 64'hF0);
    check("std_a1_data", 64'(o.data[63:32]), 64'h55667788);
    o = obs(1);
    check("std_a2_addr", 64'(o.addr), 64'h10);
    check("std_a2_mask", 64'(o.mask), 64'h0F);
    check("std_a2_data", 64'(o.data[31:0]), 64'h11223344);
    do_req(20'h0000C, 1'b0, 2'd3, 1'b0, 64'h0);
    check("ldd_0x0c", last_rdata, 64'h1122334455667788);

    mem_lat = 2;
    do_req(20'h00017, 1'b1, 2'd0, 1'b0, 64'h80);
    do_req(20'h00018, 1'b1, 2'd0, 1'b0, 64'hFF);
    do_req(20'h00017, 1'b0, 2'd1, 1'b1, 64'h0);
    check("ldh_s_split", 64'(obs_acc.size()), 64'd2);
    check("ldh_s_0x17", last_rdata, 64'hFFFFFFFFFFFFFF80);
    do_req(20'h00017, 1'b0, 2'd1, 1'b0, 64'h0);
    check("ldh_u_0x17", last_rdata, 64'h000000000000FF80);

    mem_lat = 0;
    do_req(20'hFFFFE, 1'b1, 2'd2, 1'b0, 64'h00000000DEADBEEF);
    o = obs(0);
    check("wrap_a1_addr", 64'(o.addr), 64'hFFFF8);
    check("wrap_a1_mask", 64'(o.mask), 64'hC0);
    o = obs(1);
    check("wrap_a2_addr", 64'(o.addr), 64'h00000);
    check("wrap_a2_mask", 64'(o.mask), 64'h03);
    check("wrap_addr_known", 64'($isunknown(o.addr)), 64'h0);
    do_req(20'hFFFFE, 1'b0, 2'd2, 1'b0, 64'h0);
    check("wrap_ldw_u", last_rdata, 64'h00000000DEADBEEF);
    do_req(20'hFFFFE, 1'b0, 2'd2, 1'b1, 64'h0);
    check("wrap_ldw_s", last_rdata, 64'hFFFFFFFFDEADBEEF);

    mem_lat = 1;
    do_req(20'h00021, 1'b1, 2'd1, 1'b0, 64'hFFFFFFFFFFFF8123);
    do_req(20'h00025, 1'b1, 2'd2, 1'b0, 64'h0000000089ABCDEF);
    do_req(20'h0002F, 1'b1, 2'd1, 1'b0, 64'h7F01);
    do_req(20'h00040, 1'b1, 2'd3, 1'b0, 64'h0102030405060708);
    mem_lat = 0;
    do_req(20'h00022, 1'b0, 2'd0, 1'b1, 64'h0);
    check("ldb_s_0x22", last_rdata, 64'hFFFFFFFFFFFFFF81);
    do_req(20'h00025, 1'b0, 2'd2, 1'b1, 64'h0);
    check("ldw_s_0x25", last_rdata, 64'hFFFFFFFF89ABCDEF);
    do_req(20'h0002F, 1'b0, 2'd1, 1'b1, 64'h0);
    check("ldh_s_0x2f", last_rdata, 64'h0000000000007F01);
    mem_lat = 2;
    do_req(20'h00021, 1'b0, 2'd3, 1'b0, 64'h0);
    do_req(20'h00043, 1'b0, 2'd1, 1'b0, 64'h0);
    check("ldh_u_0x43", last_rdata, 64'h0000000000000405);
    do_req(20'h00040, 1'b0, 2'd3, 1'b1, 64'h0);
    check("ldd_0x40", last_rdata, 64'h0102030405060708);

    // Abort a split load during its second access.
    mem_lat = 3;
    start_req(20'h0000C, 1'b0, 2'd3, 1'b0, 64'h0);
    t = 0;
    while (!(mem_start_access && mem_address == 20'h00010) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("abort_reached_second", 64'(t < 100), 64'h1);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("abort_start_drop", 64'(mem_start_access), 64'h0);
    check("abort_no_resp", 64'(resp_valid), 64'h0);
    exp_acc.delete();
    exp_resp.delete();
    n_accept--;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_ready_after", 64'(req_ready), 64'h1);
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_late_resp", 64'(n_resp), 64'(n_accept));

    mem_lat = 1;
    do_req(20'h0000C, 1'b0, 2'd3, 1'b0, 64'h0);
    check("post_abort_ldd", last_rdata, 64'h1122334455667788);

    repeat (3) @(posedge clk);
    #1;
    check("acc_drained", 64'(exp_acc.size()), 64'h0);
    check("resp_drained", 64'(exp_resp.size()), 64'h0);
    check("one_resp_per_req", 64'(n_resp), 64'(n_accept));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
